// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter encodings: FSM states and grant IDs.
// Imported by the picker and the arbiter top.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_D  = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and memory-side signals of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_adr;
    logic                  if_flush;
    logic                  if_ready;
    logic [DATA_W-1:0]     if_data;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_adr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wmask;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_data;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_adr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [DATA_W-1:0]     mem_rdata;

    modport slave (
        input  if_req, if_adr, if_flush,
        input  d_req, d_we, d_adr, d_wdata, d_wmask,
        input  mem_rdata,
        output if_ready, if_data, d_ready, d_data,
        output mem_en, mem_we, mem_adr, mem_wdata, mem_wmask
    );

    modport master (
        output if_req, if_adr, if_flush,
        output d_req, d_we, d_adr, d_wdata, d_wmask,
        output mem_rdata,
        input  if_ready, if_data, d_ready, d_data,
        input  mem_en, mem_we, mem_adr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/mem_arbiter_arb_rr2.sv
// Two-way round-robin picker; a tie goes to the side not granted last.
// gnt[0] = fetch, gnt[1] = data.
module arb_rr2
    import mem_arbiter_pkg::*;
(
    input  logic       req_if,
    input  logic       req_d,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (req_if && req_d) begin
            gnt = (last_grant == GNT_IF) ? 2'b10 : 2'b01;
        end else if (req_if) begin
            gnt = 2'b01;
        end else if (req_d) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between fetch and load/store.
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP; fetches can be flushed.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus,
    output logic           busy
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    arb_state_e      state;
    arb_state_e      state_nxt;
    logic            last_grant;
    logic            drop;
    logic [CW-1:0]   cnt;
    logic [1:0]      gnt;
    logic            if_flush_hit;

    arb_rr2 u_rr (
        .req_if     (bus.if_req && !bus.if_flush),
        .req_d      (bus.d_req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    assign busy         = (state != ARB_IDLE);
    assign if_flush_hit = (last_grant == GNT_IF) && bus.if_flush;

    always_ff @(posedge clk) begin
        if (rst) state <= ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:  if (|gnt) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = ARB_WAIT;
            ARB_WAIT:  if (cnt == '0) state_nxt = ARB_RESP;
            ARB_RESP:  state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_adr   <= {ADDR_W{1'b0}};
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_wmask <= {(DATA_W/8){1'b0}};
            bus.if_ready  <= 1'b0;
            bus.if_data   <= {DATA_W{1'b0}};
            bus.d_ready   <= 1'b0;
            bus.d_data    <= {DATA_W{1'b0}};
            last_grant    <= GNT_IF;
            drop          <= 1'b0;
            cnt           <= '0;
        end else begin
            bus.mem_en   <= 1'b0;
            bus.if_ready <= 1'b0;
            bus.d_ready  <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    drop <= 1'b0;
                    if (gnt[1]) begin
                        last_grant    <= GNT_D;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_adr   <= bus.d_adr;
                        bus.mem_wdata <= bus.d_wdata;
                        bus.mem_wmask <= bus.d_we ? bus.d_wmask
                                                  : {(DATA_W/8){1'b0}};
                    end else if (gnt[0]) begin
                        last_grant    <= GNT_IF;
                        bus.mem_en    <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_adr   <= bus.if_adr;
                        bus.mem_wdata <= {DATA_W{1'b0}};
                        bus.mem_wmask <= {(DATA_W/8){1'b0}};
                    end
                end
                ARB_ISSUE: begin
                    cnt <= CNT_INIT;
                    if (if_flush_hit) drop <= 1'b1;
                end
                ARB_WAIT: begin
                    if (if_flush_hit) drop <= 1'b1;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (last_grant == GNT_D) begin
                        bus.d_ready <= 1'b1;
                        if (!bus.mem_we) bus.d_data <= bus.mem_rdata;
                    end else if (!(drop || bus.if_flush)) begin
                        // a flush in this last WAIT cycle still cancels
                        bus.if_ready <= 1'b1;
                        bus.if_data  <= bus.mem_rdata;
                    end
                end
                ARB_RESP: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: two arbiter instances, MEM_LAT=1 (b1) and MEM_LAT=3 (b3).
// Cycle c = c-th posedge after the request was first presented, sampled #1 later.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    logic busy1;
    logic busy3;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [136:0] v;

    always #5 clk = ~clk;

    mem_arbiter_if b1 ();
    mem_arbiter_if b3 ();

    mem_arbiter #(.MEM_LAT(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst1),
        .bus  (b1),
        .busy (busy1)
    );

    mem_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clk  (clk),
        .rst  (rst3),
        .bus  (b3),
        .busy (busy3)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic init_inputs;
        b1.if_req = 0; b1.if_adr = '0; b1.if_flush = 0;
        b1.d_req = 0; b1.d_we = 0; b1.d_adr = '0;
        b1.d_wdata = '0; b1.d_wmask = '0; b1.mem_rdata = '0;
        b3.if_req = 0; b3.if_adr = '0; b3.if_flush = 0;
        b3.d_req = 0; b3.d_we = 0; b3.d_adr = '0;
        b3.d_wdata = '0; b3.d_wmask = '0; b3.mem_rdata = '0;
    endtask

    task automatic test_reset;
        rst1 = 1; rst3 = 1;
        tick; tick;
        rst1 = 0; rst3 = 0;
        v = {b1.mem_en, b1.mem_we, b1.mem_adr, b1.mem_wdata,
             b1.mem_wmask, b1.if_ready, b1.if_data, b1.d_ready,
             b1.d_data, busy1};
        n_cmp++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL reset_dut1: got %h want 0", v);
        end
        v = {b3.mem_en, b3.mem_we, b3.mem_adr, b3.mem_wdata,
             b3.mem_wmask, b3.if_ready, b3.if_data, b3.d_ready,
             b3.d_data, busy3};
        n_cmp++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL reset_dut3: got %h want 0", v);
        end
    endtask

    task automatic test_fetch_only;
        int d_seen = 0;
        b1.if_adr = 32'h10;
        b1.mem_rdata = 32'h0000_0013;
        b1.if_req = 1;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (b1.d_ready) d_seen++;
            if (c == 1) begin
                n_cmp++;
                if ({b1.mem_en, b1.mem_we, b1.mem_adr}
                    !== {1'b1, 1'b0, 32'h10}) begin
                    n_err++;
                    $display("FAIL fetch_issue: got en=%b we=%b adr=%h want 1 0 10",
                             b1.mem_en, b1.mem_we, b1.mem_adr);
                end
            end
            if (c == 2) begin
                n_cmp++;
                if ({b1.if_ready, b1.mem_en} !== 2'b00) begin
                    n_err++;
                    $display("FAIL fetch_wait: got rdy=%b en=%b want 0 0",
                             b1.if_ready, b1.mem_en);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({b1.if_ready, b1.if_data} !== {1'b1, 32'h13}) begin
                    n_err++;
                    $display("FAIL fetch_resp: got rdy=%b data=%h want 1 00000013",
                             b1.if_ready, b1.if_data);
                end
                b1.if_req = 0;
            end
            if (c == 4) begin
                n_cmp++;
                if ({b1.if_ready, busy1} !== 2'b00) begin
                    n_err++;
                    $display("FAIL fetch_idle: got rdy=%b busy=%b want 0 0",
                             b1.if_ready, busy1);
                end
            end
        end
        n_cmp++;
        if (d_seen !== 0) begin
            n_err++;
            $display("FAIL fetch_no_dready: got %0d pulses want 0", d_seen);
        end
    endtask

    task automatic test_alternate;
        logic [39:0] got [4];
        logic [39:0] exp [4];
        int ng = 0;
        int nd = 0;
        int ni = 0;
        exp[0] = {8'd1, 32'h20};
        exp[1] = {8'd5, 32'h30};
        exp[2] = {8'd9, 32'h20};
        exp[3] = {8'd13, 32'h30};
        for (int i = 0; i < 4; i++) got[i] = '0;
        rst1 = 1; tick; rst1 = 0;
        b1.if_adr = 32'h30;
        b1.d_adr = 32'h20;
        b1.d_we = 0;
        b1.mem_rdata = 32'h55;
        b1.if_req = 1;
        b1.d_req = 1;
        for (int c = 1; c <= 16; c++) begin
            tick;
            if (b1.mem_en && ng < 4) begin
                got[ng] = {8'(c), b1.mem_adr};
                ng++;
            end
            if (b1.d_ready) nd++;
            if (b1.if_ready) ni++;
        end
        b1.if_req = 0;
        b1.d_req = 0;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (got[i] !== exp[i]) begin
                n_err++;
                $display("FAIL alt_grant%0d: got cyc/adr %h want %h",
                         i, got[i], exp[i]);
            end
        end
        n_cmp++;
        if (nd !== 2 || ni !== 2) begin
            n_err++;
            $display("FAIL alt_ready_count: got d=%0d if=%0d want 2 2", nd, ni);
        end
        n_cmp++;
        if ({b1.d_data, b1.if_data} !== {32'h55, 32'h55}) begin
            n_err++;
            $display("FAIL alt_data: got d=%h if=%h want 55 55",
                     b1.d_data, b1.if_data);
        end
    endtask

    task automatic test_data_write;
        b1.d_we = 1;
        b1.d_adr = 32'h40;
        b1.d_wdata = 32'hDEAD_BEEF;
        b1.d_wmask = 4'b0011;
        b1.mem_rdata = 32'hAAAA_AAAA;
        b1.d_req = 1;
        for (int c = 1; c <= 4; c++) begin
            tick;
            if (c == 1) begin
                n_cmp++;
                if ({b1.mem_en, b1.mem_we, b1.mem_adr, b1.mem_wdata, b1.mem_wmask}
                    !== {1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 4'b0011}) begin
                    n_err++;
                    $display("FAIL wr_issue: got en=%b we=%b adr=%h wd=%h m=%b",
                             b1.mem_en, b1.mem_we, b1.mem_adr,
                             b1.mem_wdata, b1.mem_wmask);
                end
            end
            if (c == 3) begin
                n_cmp++;
                if ({b1.d_ready, b1.d_data} !== {1'b1, 32'h55}) begin
                    n_err++;
                    $display("FAIL wr_resp: got rdy=%b d_data=%h want 1 00000055",
                             b1.d_ready, b1.d_data);
                end
                b1.d_req = 0;
                b1.d_we = 0;
            end
            if (c == 4) begin
                n_cmp++;
                if ({b1.d_ready, b1.mem_en, b1.mem_adr, b1.mem_wmask}
                    !== {1'b0, 1'b0, 32'h40, 4'b0011}) begin
                    n_err++;
                    $display("FAIL wr_hold: got rdy=%b en=%b adr=%h m=%b",
                             b1.d_ready, b1.mem_en, b1.mem_adr, b1.mem_wmask);
                end
            end
        end
    endtask

    task automatic test_flush_idle;
        int nen = 0;
        int nif = 0;
        b1.if_adr = 32'h90;
        b1.if_req = 1;
        b1.if_flush = 1;
        b1.d_adr = 32'hA0;
        b1.d_we = 0;
        b1.mem_rdata = 32'h0BAD_F00D;
        b1.d_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (b1.mem_en) nen++;
            if (b1.if_ready) nif++;
            if (c == 1) begin
                n_cmp++;
                if ({b1.mem_adr, b1.mem_we} !== {32'hA0, 1'b0}) begin
                    n_err++;
                    $display("FAIL fl_idle_grant: got adr=%h we=%b want a0 0",
                             b1.mem_adr, b1.mem_we);
                end
                b1.if_req = 0;
                b1.if_flush = 0;
            end
            if (c == 3) begin
                n_cmp++;
                if ({b1.d_ready, b1.d_data} !== {1'b1, 32'h0BAD_F00D}) begin
                    n_err++;
                    $display("FAIL fl_idle_dresp: got rdy=%b data=%h want 1 0badf00d",
                             b1.d_ready, b1.d_data);
                end
                b1.d_req = 0;
            end
        end
        n_cmp++;
        if (nen !== 1) begin
            n_err++;
            $display("FAIL fl_idle_issues: got %0d want 1", nen);
        end
        n_cmp++;
        if (nif !== 0) begin
            n_err++;
            $display("FAIL fl_idle_ifready: got %0d want 0", nif);
        end
    endtask

    task automatic test_flush_wait;
        int nif = 0;
        int rc = 0;
        b3.if_adr = 32'h70;
        b3.mem_rdata = 32'hBAD0_BAD0;
        b3.if_req = 1;
        for (int c = 1; c <= 7; c++) begin
            tick;
            if (b3.if_ready) nif++;
            if (c == 1) begin
                n_cmp++;
                if ({b3.mem_en, b3.mem_adr} !== {1'b1, 32'h70}) begin
                    n_err++;
                    $display("FAIL flw_issue: got en=%b adr=%h want 1 70",
                             b3.mem_en, b3.mem_adr);
                end
            end
            if (c == 3) begin
                b3.if_flush = 1;
                b3.if_req = 0;
            end
            if (c == 4) b3.if_flush = 0;
            if (c == 5) begin
                n_cmp++;
                if (busy3 !== 1'b1) begin
                    n_err++;
                    $display("FAIL flw_completes: got busy=%b want 1", busy3);
                end
            end
        end
        n_cmp++;
        if (nif !== 0) begin
            n_err++;
            $display("FAIL flw_no_ready: got %0d pulses want 0", nif);
        end
        n_cmp++;
        if (b3.if_data !== 32'h0) begin
            n_err++;
            $display("FAIL flw_data_kept: got %h want 0", b3.if_data);
        end
        b3.if_adr = 32'h80;
        b3.mem_rdata = 32'h1234_5678;
        b3.if_req = 1;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c == 1) begin
                n_cmp++;
                if ({b3.mem_en, b3.mem_adr} !== {1'b1, 32'h80}) begin
                    n_err++;
                    $display("FAIL flw_next_issue: got en=%b adr=%h want 1 80",
                             b3.mem_en, b3.mem_adr);
                end
            end
            if (b3.if_ready && rc == 0) begin
                rc = c;
                b3.if_req = 0;
            end
        end
        b3.if_req = 0;
        n_cmp++;
        if (rc !== 5) begin
            n_err++;
            $display("FAIL flw_next_latency: got ready at cycle %0d want 5", rc);
        end
        n_cmp++;
        if (b3.if_data !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL flw_next_data: got %h want 12345678", b3.if_data);
        end
    endtask

    task automatic test_reset_mid;
        int nr = 0;
        b3.d_adr = 32'h44;
        b3.d_we = 0;
        b3.mem_rdata = 32'hCAFE_F00D;
        b3.d_req = 1;
        tick;
        tick;
        rst3 = 1;
        b3.d_req = 0;
        tick;
        rst3 = 0;
        v = {b3.mem_en, b3.mem_we, b3.mem_adr, b3.mem_wdata,
             b3.mem_wmask, b3.if_ready, b3.if_data, b3.d_ready,
             b3.d_data, busy3};
        n_cmp++;
        if (v !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %h want 0", v);
        end
        for (int c = 4; c <= 12; c++) begin
            tick;
            if (b3.d_ready || b3.if_ready || b3.mem_en) nr++;
        end
        n_cmp++;
        if (nr !== 0) begin
            n_err++;
            $display("FAIL rst_mid_quiet: got %0d pulses want 0", nr);
        end
    endtask

    initial begin
        rst1 = 1;
        rst3 = 1;
        init_inputs;
        test_reset;
        test_fetch_only;
        test_alternate;
        test_data_write;
        test_flush_idle;
        test_flush_wait;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
